dc_ipu_tc_gen: RTL

Texture-coordinate generator for the IPU scaler. It sits directly upstream of the gather stage. For each output line it produces one fixed-point horizontal texture coordinate per destination pixel, split into a signed integer texel index and a fraction, on the `tc_*` valid/ready interface. It steps a phase accumulator by a programmed scale increment and stops after a programmed destination width.

---
 rtl/dc_ipu_pkg.sv | 18 +
 rtl/dc_ipu_tc_gen.sv | 118 +++++++++++
 2 files changed

// File: rtl/dc_ipu_pkg.sv
// rtl/dc_ipu_pkg.sv - shared IPU scaler types and default widths
//
// Purpose : types and constants shared by the IPU scaler blocks.
// Contents: tc_gen FSM state enum, default texture-coordinate widths.

package dc_ipu_pkg;

    localparam int TEX_SIZE_WIDTH_DEF  = 12;
    localparam int TEX_FRACT_WIDTH_DEF = 6;
    localparam int ACC_FRACT_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        TC_IDLE = 2'd0,
        TC_RUN  = 2'd1,
        TC_DONE = 2'd2
    } tc_state_e;

endpackage

// File: rtl/dc_ipu_tc_gen.sv
// rtl/dc_ipu_tc_gen.sv - horizontal texture-coordinate generator for the scaler
//
// Purpose : emits one fixed-point texture coordinate per destination pixel of a
//           line, stepping a phase accumulator by a programmed increment.
// Ports   : clk, reset           - clock, asynchronous active-high reset
//           ctl_start/ctl_abort  - begin (or restart) / terminate a line
//           ctl_dst_width        - coordinates per line
//           ctl_tc_start         - first coordinate, signed fixed point
//           ctl_tc_step          - per-pixel increment, unsigned fixed point
//           ctl_busy/ctl_done    - line in progress / normal-completion pulse
//           tc_valid/tc_ready    - coordinate handshake toward gather
//           tc_int/tc_fract      - floor of coordinate / truncated fraction

module dc_ipu_tc_gen
    import dc_ipu_pkg::*;
#(
    parameter int TEX_SIZE_WIDTH  = TEX_SIZE_WIDTH_DEF,
    parameter int TEX_FRACT_WIDTH = TEX_FRACT_WIDTH_DEF,
    parameter int ACC_FRACT_WIDTH = ACC_FRACT_WIDTH_DEF
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        ctl_start,
    input  logic                                        ctl_abort,
    input  logic [TEX_SIZE_WIDTH-1:0]                   ctl_dst_width,
    input  logic signed [TEX_SIZE_WIDTH+ACC_FRACT_WIDTH-1:0] ctl_tc_start,
    input  logic [TEX_SIZE_WIDTH+ACC_FRACT_WIDTH-1:0]   ctl_tc_step,
    output logic                                        ctl_busy,
    output logic                                        ctl_done,
    output logic                                        tc_valid,
    input  logic                                        tc_ready,
    output logic signed [TEX_SIZE_WIDTH-1:0]            tc_int,
    output logic [TEX_FRACT_WIDTH-1:0]                  tc_fract
);

    localparam int ACC_W = TEX_SIZE_WIDTH + ACC_FRACT_WIDTH;
    localparam logic [TEX_SIZE_WIDTH-1:0] CNT_ONE = TEX_SIZE_WIDTH'(1);
    localparam logic [TEX_SIZE_WIDTH-1:0] CNT_ZERO = '0;

    tc_state_e                 r_state;
    tc_state_e                 w_state_nxt;
    logic [ACC_W-1:0]          r_acc;
    logic [ACC_W-1:0]          r_step;
    logic [TEX_SIZE_WIDTH-1:0] r_width;
    logic [TEX_SIZE_WIDTH-1:0] r_cnt;
    logic                      w_xfer;
    logic                      w_last;

    assign w_xfer = (r_state == TC_RUN) && tc_ready;
    assign w_last = (r_cnt == (r_width - CNT_ONE));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= TC_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: abort beats start, start beats normal progress,
    // so a start in any state restarts the line.
    always_comb begin
        w_state_nxt = r_state;
        if (ctl_abort) begin
            w_state_nxt = TC_IDLE;
        end else if (ctl_start) begin
            w_state_nxt = (ctl_dst_width == CNT_ZERO) ? TC_DONE : TC_RUN;
        end else begin
            case (r_state)
                TC_IDLE: w_state_nxt = TC_IDLE;
                TC_RUN:  w_state_nxt = (w_xfer && w_last) ? TC_DONE : TC_RUN;
                TC_DONE: w_state_nxt = TC_IDLE;
                default: w_state_nxt = TC_IDLE;
            endcase
        end
    end

    // Output decode: everything comes straight from registers, so tc_ready
    // never reaches tc_valid or the coordinate combinationally.
    always_comb begin
        ctl_busy = 1'b0;
        tc_valid = 1'b0;
        ctl_done = 1'b0;
        case (r_state)
            TC_RUN: begin
                ctl_busy = 1'b1;
                tc_valid = 1'b1;
            end
            TC_DONE: ctl_done = 1'b1;
            default: ;
        endcase
    end

    // Accumulator and pixel counter. Loading on start also discards any
    // coordinate that was waiting for acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc   <= '0;
            r_step  <= '0;
            r_width <= '0;
            r_cnt   <= '0;
        end else if (ctl_start && !ctl_abort) begin
            r_acc   <= ctl_tc_start;
            r_step  <= ctl_tc_step;
            r_width <= ctl_dst_width;
            r_cnt   <= '0;
        end else if (w_xfer && !ctl_abort) begin
            r_acc   <= r_acc + r_step;
            r_cnt   <= r_cnt + CNT_ONE;
        end
    end

    // Integer part is the arithmetic floor of the two's-complement value.
    assign tc_int   = r_acc[ACC_W-1:ACC_FRACT_WIDTH];
    assign tc_fract = r_acc[ACC_FRACT_WIDTH-1:ACC_FRACT_WIDTH-TEX_FRACT_WIDTH];

endmodule
